// File: rtl/color_pkg.sv
// Shared colour codes, counter widths and controller state encoding for the
// colour byte assembler.
package color_pkg;

  localparam int unsigned COLOR_W = 2;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned INDEX_W = 2;
  localparam int unsigned COUNT_W = 4;
  localparam int unsigned TIMER_W = 24;

  typedef enum logic [COLOR_W-1:0] {
    RED    = 2'b00,
    GREEN  = 2'b01,
    BLUE   = 2'b10,
    YELLOW = 2'b11
  } colorCode;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQUEST   = 3'd1,
    WAIT_DONE = 3'd2,
    COMPARE   = 3'd3,
    STEP      = 3'd4,
    WAIT_STEP = 3'd5,
    OUTPUT    = 3'd6
  } stateType;

  // Append one colour code at the low end; position 0 ends up in the top bits.
  function automatic logic [BYTE_W-1:0] shiftIn(input logic [BYTE_W-1:0] b,
                                                 input logic [COLOR_W-1:0] c);
    return {b[BYTE_W-COLOR_W-1:0], c};
  endfunction

endpackage

// File: rtl/agreement_filter.sv
// Tracks the run of identical colour samples at one card position and flags
// the sample that completes the required run length.
module agreement_filter
  import color_pkg::*;
#(
  parameter int unsigned SAMPLES_REQUIRED = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               sample,
  input  logic               first,
  input  logic [COLOR_W-1:0] color,
  output logic               acceptC
);

  localparam logic [COUNT_W-1:0] REQUIRED = COUNT_W'(SAMPLES_REQUIRED);

  logic [COLOR_W-1:0] lastColor;
  logic [COUNT_W-1:0] matchCount;
  logic [COUNT_W-1:0] matchNext;

  // A new run starts on the first sample of a position or on any disagreement.
  always_comb begin
    matchNext = matchCount + COUNT_W'(1);
    if (first || (color != lastColor)) begin
      matchNext = COUNT_W'(1);
    end
  end

  assign acceptC = sample && (matchNext >= REQUIRED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lastColor  <= '0;
      matchCount <= '0;
    end else if (clear) begin
      lastColor  <= '0;
      matchCount <= '0;
    end else if (sample) begin
      lastColor  <= color;
      matchCount <= matchNext;
    end
  end

endmodule

// File: rtl/color_byte_assembler.sv
// Drives the colour detector and card stepper across four positions, accepts
// each symbol after agreeing detections and hands the packed byte downstream.
module color_byte_assembler
  import color_pkg::*;
#(
  parameter int unsigned SYMBOLS          = 4,
  parameter int unsigned SAMPLES_REQUIRED = 3,
  parameter int unsigned MAX_ATTEMPTS     = 8,
  parameter int unsigned TIMEOUT_TICKS    = 24'hFFFFFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startRead,
  output logic               startDetection,
  input  logic               detectionComplete,
  input  logic [COLOR_W-1:0] color,
  output logic               stepRequest,
  input  logic               stepDone,
  output logic [BYTE_W-1:0]  byteOut,
  output logic               byteValid,
  input  logic               byteReady,
  output logic               busy,
  output logic               error,
  output logic [INDEX_W-1:0] symbolIndex
);

  localparam logic [INDEX_W-1:0] LAST_INDEX    = INDEX_W'(SYMBOLS - 1);
  localparam logic [COUNT_W-1:0] ATTEMPT_LIMIT = COUNT_W'(MAX_ATTEMPTS);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST  = TIMER_W'(TIMEOUT_TICKS - 1);

  stateType           state, stateNext;
  logic [BYTE_W-1:0]  shiftReg, shiftNext, byteOutNext;
  logic [COUNT_W-1:0] attempts, attemptsNext;
  logic [TIMER_W-1:0] timer, timerNext;
  logic [COLOR_W-1:0] capturedColor, capturedNext;
  logic [INDEX_W-1:0] indexNext;
  logic               errorNext, startDetectionNext, stepRequestNext;
  logic               byteValidNext, busyNext;
  logic               filterClear, filterSample, acceptC;

  agreement_filter #(
    .SAMPLES_REQUIRED(SAMPLES_REQUIRED)
  ) filter (
    .clk    (clk),
    .reset  (reset),
    .clear  (filterClear),
    .sample (filterSample),
    .first  (attempts == COUNT_W'(1)),
    .color  (capturedColor),
    .acceptC(acceptC)
  );

  // Next-state and next-output logic; strobes are derived from the next state
  // so every output leaves a flop.
  always_comb begin
    stateNext    = state;
    errorNext    = error;
    indexNext    = symbolIndex;
    shiftNext    = shiftReg;
    byteOutNext  = byteOut;
    attemptsNext = attempts;
    timerNext    = timer;
    capturedNext = capturedColor;
    filterClear  = 1'b0;
    filterSample = 1'b0;

    case (state)
      IDLE: begin
        if (startRead) begin
          errorNext    = 1'b0;
          indexNext    = '0;
          shiftNext    = '0;
          attemptsNext = '0;
          filterClear  = 1'b1;
          stateNext    = REQUEST;
        end
      end
      REQUEST: begin
        timerNext = '0;
        stateNext = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (detectionComplete) begin
          capturedNext = color;
          attemptsNext = attempts + COUNT_W'(1);
          stateNext    = COMPARE;
        end else if (timer >= TIMEOUT_LAST) begin
          errorNext = 1'b1;
          stateNext = IDLE;
        end else begin
          timerNext = timer + TIMER_W'(1);
        end
      end
      COMPARE: begin
        filterSample = 1'b1;
        if (acceptC) begin
          shiftNext = shiftIn(shiftReg, capturedColor);
          if (symbolIndex == LAST_INDEX) begin
            byteOutNext = shiftIn(shiftReg, capturedColor);
            stateNext   = OUTPUT;
          end else begin
            stateNext = STEP;
          end
        end else if (attempts >= ATTEMPT_LIMIT) begin
          errorNext = 1'b1;
          stateNext = IDLE;
        end else begin
          stateNext = REQUEST;
        end
      end
      STEP: begin
        timerNext = '0;
        stateNext = WAIT_STEP;
      end
      WAIT_STEP: begin
        if (stepDone) begin
          indexNext    = symbolIndex + INDEX_W'(1);
          attemptsNext = '0;
          filterClear  = 1'b1;
          stateNext    = REQUEST;
        end else if (timer >= TIMEOUT_LAST) begin
          errorNext = 1'b1;
          stateNext = IDLE;
        end else begin
          timerNext = timer + TIMER_W'(1);
        end
      end
      OUTPUT: begin
        if (byteReady) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase

    startDetectionNext = (stateNext == REQUEST);
    stepRequestNext    = (stateNext == STEP) || (stateNext == WAIT_STEP);
    byteValidNext      = (stateNext == OUTPUT);
    busyNext           = (stateNext != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      startDetection <= 1'b0;
      stepRequest    <= 1'b0;
      byteOut        <= '0;
      byteValid      <= 1'b0;
      busy           <= 1'b0;
      error          <= 1'b0;
      symbolIndex    <= '0;
      shiftReg       <= '0;
      attempts       <= '0;
      timer          <= '0;
      capturedColor  <= '0;
    end else begin
      state          <= stateNext;
      startDetection <= startDetectionNext;
      stepRequest    <= stepRequestNext;
      byteOut        <= byteOutNext;
      byteValid      <= byteValidNext;
      busy           <= busyNext;
      error          <= errorNext;
      symbolIndex    <= indexNext;
      shiftReg       <= shiftNext;
      attempts       <= attemptsNext;
      timer          <= timerNext;
      capturedColor  <= capturedNext;
    end
  end

endmodule

// File: tb/tb_color_byte_assembler.sv
// Self-checking bench for color_byte_assembler: mock detector and stepper,
// directed and random colour streams checked against a sequence-level model.
module tb_color_byte_assembler;
  import color_pkg::*;

  localparam int unsigned SR   = 3;
  localparam int unsigned MAXA = 8;
  localparam int unsigned TMO  = 100;

  logic       clk;
  logic       reset;
  logic       startRead;
  logic       startDetection;
  logic       detectionComplete;
  logic [1:0] color;
  logic       stepRequest;
  logic       stepDone;
  logic [7:0] byteOut;
  logic       byteValid;
  logic       byteReady;
  logic       busy;
  logic       error;
  logic [1:0] symbolIndex;

  int checks = 0;
  int errors = 0;
  int detCount = 0;
  int stepCount = 0;
  int overlapCount = 0;
  int validCount = 0;
  int detServed = 0;
  int seqBase = 0;
  bit hangDetector = 0;
  logic [1:0] curSeq[$];

  color_byte_assembler #(
    .SYMBOLS(4), .SAMPLES_REQUIRED(SR), .MAX_ATTEMPTS(MAXA), .TIMEOUT_TICKS(TMO)
  ) dut (
    .clk(clk), .reset(reset), .startRead(startRead),
    .startDetection(startDetection), .detectionComplete(detectionComplete),
    .color(color), .stepRequest(stepRequest), .stepDone(stepDone),
    .byteOut(byteOut), .byteValid(byteValid), .byteReady(byteReady),
    .busy(busy), .error(error), .symbolIndex(symbolIndex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: walk the detection stream position by position using run lengths.
  function automatic void model(input logic [1:0] seq[$], output logic [7:0] b,
                                output bit err, output int dets, output int steps);
    int run, tries;
    logic [1:0] last, c;
    bit got;
    b = 8'h00; err = 0; dets = 0; steps = 0;
    for (int p = 0; p < 4 && !err; p++) begin
      run = 0; tries = 0; last = 2'b00; got = 0;
      while (!got && !err) begin
        c = (dets < seq.size()) ? seq[dets] : 2'b00;
        dets++; tries++;
        if (tries == 1 || c != last) begin run = 1; last = c; end
        else run++;
        if (run == int'(SR)) begin
          got = 1;
          b = (b << 2) | {6'd0, c};
          if (p < 3) steps++;
        end else if (tries == int'(MAXA)) begin
          err = 1;
        end
      end
    end
  endfunction

  // Event monitor: pulses, forbidden overlap, byteValid occupancy.
  initial forever begin
    @(negedge clk);
    if (startDetection) detCount++;
    if (startDetection && stepRequest) overlapCount++;
    if (byteValid) validCount++;
  end

  // Mock colour detector: answers each request after 1..4 cycles.
  initial begin
    int d;
    detectionComplete = 1'b0;
    color = 2'b00;
    forever begin
      @(negedge clk);
      if (startDetection && !hangDetector) begin
        d = $urandom_range(1, 4);
        repeat (d) @(negedge clk);
        color = (detServed - seqBase < curSeq.size()) ? curSeq[detServed - seqBase] : 2'b00;
        detServed++;
        detectionComplete = 1'b1;
        @(negedge clk);
        detectionComplete = 1'b0;
        color = 2'($urandom_range(0, 3));
      end
    end
  end

  // Mock stepper: stepDone five cycles after each stepRequest, if still requested.
  initial begin
    stepDone = 1'b0;
    forever begin
      @(negedge clk);
      if (stepRequest) begin
        stepCount++;
        repeat (5) @(negedge clk);
        if (stepRequest) begin
          stepDone = 1'b1;
          @(negedge clk);
          stepDone = 1'b0;
        end
        while (stepRequest) @(negedge clk);
      end
    end
  end

  task automatic runRead(input logic [1:0] seq[$], input int holdCycles);
    logic [7:0] expByte;
    bit expErr, done;
    int expDets, expSteps, detBase, stepBase, ovBase, valBase, detAtValid, unstable;
    model(seq, expByte, expErr, expDets, expSteps);
    curSeq = seq;
    seqBase = detServed;
    detBase = detCount; stepBase = stepCount; ovBase = overlapCount; valBase = validCount;
    @(negedge clk); startRead = 1'b1;
    @(negedge clk); startRead = 1'b0;
    checkValue("busyStart", 32'(busy), 1);
    checkValue("errCleared", 32'(error), 0);
    done = 0;
    for (int i = 0; i < 4000 && !done; i++) begin
      if (byteValid || !busy) done = 1;
      else @(negedge clk);
    end
    checkValue("readDone", 32'(done), 1);
    if (expErr) begin
      checkValue("errSet", 32'(error), 1);
      checkValue("busyIdle", 32'(busy), 0);
      checkValue("noValid", 32'(validCount - valBase), 0);
    end else begin
      checkValue("byteValid", 32'(byteValid), 1);
      checkValue("byteOut", 32'(byteOut), 32'(expByte));
      checkValue("lastIndex", 32'(symbolIndex), 3);
      checkValue("noErr", 32'(error), 0);
      detAtValid = detCount;
      unstable = 0;
      repeat (holdCycles) begin
        @(negedge clk);
        if (!byteValid || byteOut !== expByte) unstable++;
      end
      checkValue("holdStable", 32'(unstable), 0);
      checkValue("holdNoDet", 32'(detCount - detAtValid), 0);
      byteReady = 1'b1;
      @(negedge clk);
      byteReady = 1'b0;
      checkValue("validDrop", 32'(byteValid), 0);
      checkValue("byteKept", 32'(byteOut), 32'(expByte));
      checkValue("busyAfter", 32'(busy), 0);
    end
    checkValue("detections", 32'(detCount - detBase), 32'(expDets));
    checkValue("steps", 32'(stepCount - stepBase), 32'(expSteps));
    checkValue("overlap", 32'(overlapCount - ovBase), 0);
  endtask

  initial begin
    logic [1:0] seq[$];
    logic [1:0] prev;
    int cnt, detBase;
    bit found;

    reset = 1'b1; startRead = 1'b0; byteReady = 1'b0;
    repeat (2) @(negedge clk);
    checkValue("rstStartDet", 32'(startDetection), 0);
    checkValue("rstStepReq", 32'(stepRequest), 0);
    checkValue("rstByteOut", 32'(byteOut), 0);
    checkValue("rstValid", 32'(byteValid), 0);
    checkValue("rstBusy", 32'(busy), 0);
    checkValue("rstError", 32'(error), 0);
    checkValue("rstIndex", 32'(symbolIndex), 0);
    reset = 1'b0;
    @(negedge clk);

    // Clean read with 20 cycles of backpressure.
    seq = '{2'd0,2'd0,2'd0, 2'd1,2'd1,2'd1, 2'd2,2'd2,2'd2, 2'd3,2'd3,2'd3};
    runRead(seq, 20);

    // Noise at position 0.
    seq = '{2'd0,2'd2,2'd0,2'd0,2'd0, 2'd1,2'd1,2'd1, 2'd2,2'd2,2'd2, 2'd3,2'd3,2'd3};
    runRead(seq, 0);

    // Attempt exhaustion, then a clean read that must clear error.
    seq = '{2'd0,2'd1,2'd0,2'd1,2'd0,2'd1,2'd0,2'd1};
    runRead(seq, 0);
    seq = '{2'd3,2'd3,2'd3, 2'd2,2'd2,2'd2, 2'd1,2'd1,2'd1, 2'd0,2'd0,2'd0};
    runRead(seq, 1);

    // Detection timeout: error exactly TMO cycles into WAIT_DONE.
    hangDetector = 1;
    detBase = detCount;
    @(negedge clk); startRead = 1'b1;
    @(negedge clk); startRead = 1'b0;
    checkValue("tmoRequest", 32'(startDetection), 1);
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (error) break;
      cnt++;
    end
    checkValue("tmoCycles", 32'(cnt), TMO);
    checkValue("tmoError", 32'(error), 1);
    checkValue("tmoBusy", 32'(busy), 0);
    checkValue("tmoOneDet", 32'(detCount - detBase), 1);
    hangDetector = 0;
    repeat (2) @(negedge clk);

    // Reset during WAIT_STEP, then a full read from position 0.
    seq = '{2'd1,2'd1,2'd1, 2'd0,2'd0,2'd0, 2'd3,2'd3,2'd3, 2'd2,2'd2,2'd2};
    curSeq = seq; seqBase = detServed;
    @(negedge clk); startRead = 1'b1;
    @(negedge clk); startRead = 1'b0;
    found = 0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(negedge clk);
      if (stepRequest) found = 1;
    end
    checkValue("stepSeen", 32'(found), 1);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkValue("asyncStepReq", 32'(stepRequest), 0);
    checkValue("asyncBusy", 32'(busy), 0);
    checkValue("asyncValid", 32'(byteValid), 0);
    checkValue("asyncIndex", 32'(symbolIndex), 0);
    @(negedge clk); reset = 1'b0;
    repeat (8) @(negedge clk);
    runRead(seq, 0);

    // Random streams, some noisy enough to exhaust attempts.
    for (int r = 0; r < 10; r++) begin
      seq.delete();
      prev = 2'($urandom_range(0, 3));
      for (int i = 0; i < 40; i++) begin
        if ($urandom_range(0, (r % 2) ? 1 : 4) == 0) prev = 2'($urandom_range(0, 3));
        seq.push_back(prev);
      end
      runRead(seq, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/color_byte_assembler.md
Name: color_byte_assembler

Overview:
Downstream consumer of colorDetector. Sequences repeated colour detections over SYMBOLS card positions and accepts a symbol only after SAMPLES_REQUIRED consecutive agreeing results. Commands the card-stepping mechanism between positions. Packs the 2-bit colour codes into one byte and presents it with a valid/ready handshake to the ROM read-out logic.

Parameters:
SYMBOLS, 4, colour positions per byte (fixed 4 for 8-bit packing; other values unsupported)
SAMPLES_REQUIRED, 3, consecutive identical detections needed to accept a symbol (1..7)
MAX_ATTEMPTS, 8, detections allowed per position before error (>= SAMPLES_REQUIRED, <= 15)
TIMEOUT_TICKS, 24'hFFFFFF, clk cycles allowed per wait (detection or step) before error

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
startRead  input  1  level; sampled only in IDLE; begins a byte read
startDetection  output  1  one-cycle pulse to colorDetector
detectionComplete  input  1  one-cycle pulse from colorDetector; color valid in same cycle
color  input  2  00 red, 01 green, 10 blue, 11 yellow
stepRequest  output  1  held high until stepDone; advance card one position
stepDone  input  1  one-cycle pulse from mechanism
byteOut  output  8  packed symbols; position 0 in [7:6], position 3 in [1:0]
byteValid  output  1  byteOut valid; held until accepted
byteReady  input  1  consumer accept; transfer when byteValid && byteReady
busy  output  1  high in every state except IDLE
error  output  1  sticky; set on timeout or attempt exhaustion; cleared on next accepted startRead
symbolIndex  output  2  current position (debug)

Behaviour:
- Reset (async): state IDLE. All outputs 0: startDetection, stepRequest, byteOut, byteValid, busy, error, symbolIndex. Internal counters 0. Reset mid-read abandons the byte; no output results.
- IDLE: startRead=1 -> clear error, index, shift register, match count, attempt count -> REQUEST.
- REQUEST: assert startDetection for exactly one cycle; clear timeout counter -> WAIT_DONE.
- WAIT_DONE: count ticks.
  - detectionComplete=1 -> capture color, increment attempts -> COMPARE.
  - Timeout counter reaching TIMEOUT_TICKS -> error=1 -> IDLE. A detectionComplete in the same cycle takes priority over timeout.
- COMPARE (one cycle):
  - If attempts==1 or color != lastColor: matchCount=1, lastColor=color. Otherwise matchCount+1.
  - matchCount reaching SAMPLES_REQUIRED: shift lastColor into byte (byte <= {byte[5:0],lastColor}).
    - If index==SYMBOLS-1 -> OUTPUT.
    - Otherwise -> STEP.
  - Otherwise, attempts==MAX_ATTEMPTS -> error=1 -> IDLE.
  - Otherwise -> REQUEST.
- STEP: raise stepRequest, clear timeout counter -> WAIT_STEP.
- WAIT_STEP: stepRequest held high.
  - stepDone=1 -> stepRequest=0, index+1, attempts=0, matchCount=0 -> REQUEST.
  - Timeout -> stepRequest=0, error=1 -> IDLE.
- OUTPUT: byteOut/byteValid registered on entry (one cycle after final COMPARE); both held stable until byteValid&&byteReady. In the transfer cycle, byteValid falls on the next edge -> IDLE. byteOut retains its value after transfer. No step after the last symbol.
- Latency for a noise-free byte: SYMBOLS*SAMPLES_REQUIRED detections plus SYMBOLS-1 steps, plus 1 cycle to byteValid.
- startRead is ignored outside IDLE. startDetection is never issued while stepRequest is high.
- detectionComplete or stepDone arriving in an unexpected state is ignored.
- error stays asserted in IDLE until the next startRead is accepted.
- Counter widths: attempts and matchCount 4 bits; timeout 24 bits, saturating compare.

Decomposition:
- Shared package (color_pkg): colour code constants RED=2'b00, GREEN=2'b01, BLUE=2'b10, YELLOW=2'b11; state encoding localparams.
- One natural sub-module: agreement_filter. Holds lastColor and matchCount, takes sample/clear, and outputs accept. Instantiated once.

Test Plan:
- Clean read: mock detector returns red×3, green×3, blue×3, yellow×3; stepDone 5 cycles after each stepRequest -> byteOut=8'b00011011, byteValid=1, exactly 12 startDetection pulses, 3 stepRequests.
- Noise rejection: position 0 returns red, blue, red, red, red -> symbol red accepted after 5 detections; byte [7:6]=00.
- Attempt exhaustion: alternating red/green for 8 detections -> error=1, busy=0, byteValid never asserted; next startRead clears error.
- Detection timeout: no detectionComplete with TIMEOUT_TICKS=100 -> error=1 exactly 100 ticks after WAIT_DONE entry; state IDLE.
- Backpressure: byteReady held 0 for 20 cycles after byteValid -> byteOut stable, no new startDetection; byteReady=1 -> byteValid 0 next cycle.
- Reset mid-operation: assert reset during WAIT_STEP -> stepRequest, busy and byteValid are 0 immediately (async); the next startRead performs a full read from position 0.
